// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - word request/response and byte-memory signal bundle
interface mem_access_unit_if #(
  parameter int MEM_AW = 14
);
  logic              req_valid;
  logic              req_write;
  logic [15:0]       req_addr;
  logic [15:0]       req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic [15:0]       resp_rdata;
  logic              resp_err;
  logic [MEM_AW-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic [7:0]        mem_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_wdata, mem_we
  );

  modport mem (
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - 16-bit word requests to little-endian 8-bit sync-read memory
module mem_access_unit #(
  parameter int MEM_AW     = 14,
  parameter int WORD_LIMIT = 8192
) (
  input  logic             clk,
  input  logic             reset,
  mem_access_unit_if.slave bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_LO   = 3'd1;
  localparam logic [2:0] RD_HI   = 3'd2;
  localparam logic [2:0] RD_WAIT = 3'd3;
  localparam logic [2:0] WR_LO   = 3'd4;
  localparam logic [2:0] WR_HI   = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;

  logic [2:0] state;
  logic [7:0] wdata_hi;
  logic       addr_err;

  assign addr_err = {16'd0, bus.req_addr} >= 32'(WORD_LIMIT);

  // Outputs are registered against the state being entered, so each state's
  // memory drive is already present during that state's cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      wdata_hi       <= 8'd0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= 16'd0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
            if (addr_err) begin
              state          <= DONE;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= 16'd0;
            end else if (bus.req_write) begin
              state         <= WR_LO;
              wdata_hi      <= bus.req_wdata[15:8];
              bus.mem_addr  <= {bus.req_addr[MEM_AW-2:0], 1'b0};
              bus.mem_wdata <= bus.req_wdata[7:0];
              bus.mem_we    <= 1'b1;
            end else begin
              state        <= RD_LO;
              bus.mem_addr <= {bus.req_addr[MEM_AW-2:0], 1'b0};
            end
          end
        end
        RD_LO: begin
          state        <= RD_HI;
          bus.mem_addr <= {bus.mem_addr[MEM_AW-1:1], 1'b1};
        end
        RD_HI: begin
          // Low byte returns one edge after its address was presented.
          state                <= RD_WAIT;
          bus.resp_rdata[7:0]  <= bus.mem_rdata;
        end
        RD_WAIT: begin
          state                <= DONE;
          bus.resp_rdata[15:8] <= bus.mem_rdata;
          bus.resp_valid       <= 1'b1;
        end
        WR_LO: begin
          state         <= WR_HI;
          bus.mem_addr  <= {bus.mem_addr[MEM_AW-1:1], 1'b1};
          bus.mem_wdata <= wdata_hi;
        end
        WR_HI: begin
          state          <= DONE;
          bus.mem_we     <= 1'b0;
          bus.resp_valid <= 1'b1;
        end
        DONE: begin
          state          <= IDLE;
          bus.resp_valid <= 1'b0;
          bus.resp_err   <= 1'b0;
          bus.req_ready  <= 1'b1;
        end
        default: begin
          state          <= IDLE;
          bus.mem_we     <= 1'b0;
          bus.resp_valid <= 1'b0;
          bus.resp_err   <= 1'b0;
          bus.req_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
